// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding and defaults for the bit-serial adder
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/fa.sv
// rtl/fa.sv - single-bit full adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Purely combinational sum and carry of three input bits.
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller time-sharing one fa cell
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last_bit;

  // The single adder cell always sees the current LSBs and the stored carry.
  fa u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // A new operation is taken only when not running; start during RUN is dropped.
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_bit = (state == S_RUN) && (cnt == LAST);

  // Handshake outputs decode the state register only.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (cnt == LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand load, per-bit shift/carry update and result capture on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else if (accept) begin
      a_sr  <= a_in;
      b_sr  <= b_in;
      carry <= cin_in;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      s_sr  <= {fa_sum, s_sr[WIDTH-1:1]};
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      carry <= fa_carry;
      cnt   <= cnt + 1'b1;
      if (last_bit) begin
        sum_out  <= {fa_sum, s_sr[WIDTH-1:1]};
        cout_out <= fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH 8 and 2)
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout_out;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       c2;
  logic       busy2;
  logic       done2;
  logic [1:0] sum2;
  logic       cout2;

  int n_pass;
  int n_total;

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_in(a2), .b_in(b2),
    .cin_in(c2), .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_done8(output int cyc, output int bsy);
    cyc = 0;
    bsy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bsy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_total++;
    if ({busy, done, cout_out, sum_out} !== 11'd0) $display("FAIL reset_w8: got %h want 000", {busy, done, cout_out, sum_out});
    else n_pass++;
    n_total++;
    if ({busy2, done2, cout2, sum2} !== 5'd0) $display("FAIL reset_w2: got %h want 00", {busy2, done2, cout2, sum2});
    else n_pass++;
  endtask

  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic c, input string name);
    int         cyc;
    int         bsy;
    logic [8:0] exp;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); cin_in = 1'($urandom);
    wait_done8(cyc, bsy);
    n_total++;
    if (cyc !== 8) $display("FAIL %s_latency: got %0d want 8", name, cyc);
    else n_pass++;
    n_total++;
    if (bsy !== 8) $display("FAIL %s_busy_cycles: got %0d want 8", name, bsy);
    else n_pass++;
    exp = (q8.size() > 0) ? q8.pop_front() : 9'bx;
    n_total++;
    if ({cout_out, sum_out} !== exp) $display("FAIL %s_result: got %h want %h", name, {cout_out, sum_out}, exp);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_busy_in_done: got %b want 0", name, busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (done !== 1'b0) $display("FAIL %s_done_width: got %b want 0", name, done);
    else n_pass++;
  endtask

  task automatic test_basic();
    do_add(8'h3C, 8'h42, 1'b0, "basic_3c42");
    do_add(8'hFF, 8'h01, 1'b0, "carry_ff01");
    do_add(8'hA5, 8'h5A, 1'b1, "cin_a55a");
    do_add(8'h80, 8'h7F, 1'b0, "nocarry_807f");
  endtask

  task automatic test_ignore_start();
    int         cyc;
    int         bsy;
    int         ndone;
    logic [8:0] exp;
    q8.push_back(9'h046);
    a_in = 8'h12; b_in = 8'h34; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a_in = 8'h11; b_in = 8'h22;
    @(negedge clk);
    start = 1'b0;
    wait_done8(cyc, bsy);
    n_total++;
    if (cyc !== 4) $display("FAIL ignore_latency: got %0d want 4", cyc);
    else n_pass++;
    exp = (q8.size() > 0) ? q8.pop_front() : 9'bx;
    n_total++;
    if ({cout_out, sum_out} !== exp) $display("FAIL ignore_result: got %h want %h", {cout_out, sum_out}, exp);
    else n_pass++;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_total++;
    if (ndone !== 0) $display("FAIL ignore_extra_done: got %0d want 0", ndone);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         cyc;
    int         bsy;
    logic [8:0] exp;
    q8.push_back(9'h002);
    q8.push_back(9'h004);
    a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a_in = 8'h02; b_in = 8'h02;
    wait_done8(cyc, bsy);
    n_total++;
    if (cyc !== 8 || bsy !== 8) $display("FAIL b2b_first_timing: got %0d/%0d want 8/8", cyc, bsy);
    else n_pass++;
    exp = (q8.size() > 0) ? q8.pop_front() : 9'bx;
    n_total++;
    if ({cout_out, sum_out} !== exp) $display("FAIL b2b_first_result: got %h want %h", {cout_out, sum_out}, exp);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL b2b_reaccept: got busy=%b done=%b want 1/0", busy, done);
    else n_pass++;
    wait_done8(cyc, bsy);
    n_total++;
    if (cyc !== 8 || bsy !== 8) $display("FAIL b2b_second_timing: got %0d/%0d want 8/8", cyc, bsy);
    else n_pass++;
    exp = (q8.size() > 0) ? q8.pop_front() : 9'bx;
    n_total++;
    if ({cout_out, sum_out} !== exp) $display("FAIL b2b_second_result: got %h want %h", {cout_out, sum_out}, exp);
    else n_pass++;
    start = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int   ndone;
    logic [8:0] dropped;
    q8.push_back(9'h0FF);
    a_in = 8'hF0; b_in = 8'h0F; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    dropped = q8.pop_back();
    #1;
    n_total++;
    if ({busy, done, cout_out, sum_out} !== 11'd0) $display("FAIL midrun_async_clear: got %h want 000", {busy, done, cout_out, sum_out});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_total++;
    if (ndone !== 0) $display("FAIL midrun_no_done: got %0d want 0 (dropped %h)", ndone, dropped);
    else n_pass++;
    do_add(8'hF0, 8'h0F, 1'b0, "after_reset");
  endtask

  task automatic test_width2_sweep();
    int         cyc;
    int         ref_val;
    logic [2:0] exp;
    for (int i = 0; i < 32; i++) begin
      a2 = 2'(i >> 3); b2 = 2'(i >> 1); c2 = 1'(i);
      ref_val = ((i >> 3) & 3) + ((i >> 1) & 3) + (i & 1);
      q2.push_back(3'(ref_val));
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      cyc = 0;
      while (done2 !== 1'b1 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      n_total++;
      if (cyc !== 2) $display("FAIL w2_latency_%0d: got %0d want 2", i, cyc);
      else n_pass++;
      exp = (q2.size() > 0) ? q2.pop_front() : 3'bx;
      n_total++;
      if ({cout2, sum2} !== exp) $display("FAIL w2_result_%0d: got %h want %h", i, {cout2, sum2}, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_width2_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
